// File: rtl/uart_tx_frame_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_engine
//
// UART transmit path. Words are queued through a valid/ready write port into
// a small FIFO. Each frame is built from a popped word and a snapshot of the
// line control fields (data length, parity mode, stop bits), then shifted
// out on tx at one bit per baud_clk cycle. A break request holds the line
// low between frames.
//
// Handshake: a word is accepted on a rising edge where data_valid and
// data_ready are both high. data_ready is high whenever the FIFO is not
// full. A write presented while data_ready is low is dropped and changes
// nothing.
//
// Ports
//   baud_clk          bit clock, all state updates on its rising edge
//   rst               asynchronous active-high reset
//   line_control_reg  [3:0] data_len, [4] stop2, [6:5] parity mode
//                     (00 none, 01 odd, 10 even, 11 mark)
//   data_input        word to transmit
//   data_valid        write request
//   data_ready        FIFO not full
//   set_break         hold the line low once the current frame ends
//   tx                registered serial line, idles at 1
//   busy              a frame or break is on the line
//   frame_done        one-cycle pulse during the final stop bit
//   fifo_count        current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_frame_engine #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              baud_clk,
    input  logic                              rst,
    input  logic [6:0]                        line_control_reg,
    input  logic [DATA_W-1:0]                 data_input,
    input  logic                              data_valid,
    output logic                              data_ready,
    input  logic                              set_break,
    output logic                              tx,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MIN_LEN = 4'd5;
    localparam logic [3:0] MAX_LEN = 4'(DATA_W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign data_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = data_valid && data_ready;
    assign head       = mem[rd_ptr];

    // ------------------------------------------------------------------
    // Frame registers (snapshot taken when a word is popped)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] f_shift;
    logic [3:0]        f_len;
    logic              f_par_en;
    logic              f_par;
    logic              f_stop2;
    logic [3:0]        bit_cnt;
    logic              stop_cnt;

    // The decision point is IDLE or the edge that ends the last stop bit;
    // this is what makes back-to-back frames gapless.
    logic at_decision;
    assign at_decision = (state == IDLE) ||
                         ((state == STOP) && (stop_cnt == f_stop2));
    assign pop = at_decision && !set_break && !fifo_empty;

    // ------------------------------------------------------------------
    // Line control decode for the word about to be popped
    // ------------------------------------------------------------------
    logic [3:0]        dec_len;
    logic [DATA_W-1:0] dec_mask;
    logic              dec_xor;
    logic              dec_par;

    always_comb begin
        dec_len = line_control_reg[3:0];
        if (line_control_reg[3:0] < MIN_LEN) begin
            dec_len = MIN_LEN;
        end else if (line_control_reg[3:0] > MAX_LEN) begin
            dec_len = MAX_LEN;
        end

        // Bits above the frame length must not contribute to parity.
        dec_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            dec_mask[i] = (i < int'(dec_len));
        end
        dec_xor = ^(head & dec_mask);

        dec_par = 1'b0;
        case (line_control_reg[6:5])
            2'b01:   dec_par = ~dec_xor;
            2'b10:   dec_par = dec_xor;
            2'b11:   dec_par = 1'b1;
            default: dec_par = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge baud_clk) begin
        if (push) begin
            mem[wr_ptr] <= data_input;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM. tx, busy and frame_done are registered and always reflect
    // the state being entered.
    // ------------------------------------------------------------------
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            f_shift    <= '0;
            f_len      <= MIN_LEN;
            f_par_en   <= 1'b0;
            f_par      <= 1'b0;
            f_stop2    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (at_decision) begin
                if (set_break) begin
                    state <= BREAK;
                    tx    <= 1'b0;
                    busy  <= 1'b1;
                end else if (!fifo_empty) begin
                    state    <= START;
                    tx       <= 1'b0;
                    busy     <= 1'b1;
                    f_shift  <= head;
                    f_len    <= dec_len;
                    f_par_en <= |line_control_reg[6:5];
                    f_par    <= dec_par;
                    f_stop2  <= line_control_reg[4];
                end else begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    START: begin
                        state   <= DATA;
                        tx      <= f_shift[0];
                        f_shift <= f_shift >> 1;
                        bit_cnt <= 4'd1;
                    end
                    DATA: begin
                        // bit_cnt counts data bits already placed on tx.
                        if (bit_cnt == f_len) begin
                            if (f_par_en) begin
                                state <= PARITY;
                                tx    <= f_par;
                            end else begin
                                state      <= STOP;
                                tx         <= 1'b1;
                                stop_cnt   <= 1'b0;
                                frame_done <= !f_stop2;
                            end
                        end else begin
                            tx      <= f_shift[0];
                            f_shift <= f_shift >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        state      <= STOP;
                        tx         <= 1'b1;
                        stop_cnt   <= 1'b0;
                        frame_done <= !f_stop2;
                    end
                    STOP: begin
                        // Only reached here for the first of two stop bits.
                        stop_cnt   <= 1'b1;
                        tx         <= 1'b1;
                        frame_done <= 1'b1;
                    end
                    BREAK: begin
                        // Leaving through IDLE guarantees one mark cycle
                        // before any following start bit.
                        if (!set_break) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            tx <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_engine
//
// Directed bench for uart_tx_frame_engine (DATA_W=8, FIFO_DEPTH=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, so every sample reflects the post-edge state. When
// recording is enabled, each cycle's tx/busy/frame_done sample is shifted
// into a vector (first sample ends up most significant) and compared with a
// hand-built expected vector.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_engine;

    logic       baud_clk;
    logic       rst;
    logic [6:0] line_control_reg;
    logic [7:0] data_input;
    logic       data_valid;
    logic       data_ready;
    logic       set_break;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_count;

    int checks;
    int failures;

    logic        rec;
    logic [63:0] obs_tx;
    logic [63:0] obs_busy;
    logic [63:0] obs_done;
    logic [63:0] exp_tx;
    logic [63:0] exp_busy;
    logic [63:0] exp_done;

    logic [7:0] exp_q[$];

    uart_tx_frame_engine #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .baud_clk         (baud_clk),
        .rst              (rst),
        .line_control_reg (line_control_reg),
        .data_input       (data_input),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .set_break        (set_break),
        .tx               (tx),
        .busy             (busy),
        .frame_done       (frame_done),
        .fifo_count       (fifo_count)
    );

    // ------------------------------------------------------------------
    // Clock and watchdog
    // ------------------------------------------------------------------
    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checking and driver tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
        if (rec) begin
            obs_tx   = {obs_tx[62:0], tx};
            obs_busy = {obs_busy[62:0], busy};
            obs_done = {obs_done[62:0], frame_done};
        end
    endtask

    task automatic clear_obs();
        obs_tx   = '0;
        obs_busy = '0;
        obs_done = '0;
        exp_tx   = '0;
        exp_busy = '0;
        exp_done = '0;
    endtask

    task automatic push_exp(input logic t, input logic b, input logic d);
        exp_tx   = {exp_tx[62:0], t};
        exp_busy = {exp_busy[62:0], b};
        exp_done = {exp_done[62:0], d};
    endtask

    // Expected frame bits: pat holds the frame with the start bit in
    // position n-1 and the last stop bit in position 0.
    task automatic push_frame(input logic [15:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            push_exp(pat[i], 1'b1, (i == 0));
        end
    endtask

    task automatic compare_obs(input string tag);
        check({tag, "_tx"},   obs_tx,   exp_tx);
        check({tag, "_busy"}, obs_busy, exp_busy);
        check({tag, "_done"}, obs_done, exp_done);
    endtask

    // One word from an empty, idle engine. The start bit must appear after
    // the second edge; LCR and data are scrambled once the frame is latched.
    task automatic run_frame(input string tag, input logic [6:0] lcr,
                             input logic [7:0] data, input logic [15:0] pat,
                             input int n);
        clear_obs();
        line_control_reg = lcr;
        data_input       = data;
        data_valid       = 1'b1;
        rec              = 1'b1;
        tick();
        data_valid = 1'b0;
        check({tag, "_count"}, 64'(fifo_count), 64'd1);
        tick();
        line_control_reg = 7'($urandom_range(0, 127));
        data_input       = 8'($urandom_range(0, 255));
        for (int i = 0; i < n + 1; i++) tick();
        rec = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0);
        push_frame(pat, n);
        push_exp(1'b1, 1'b0, 1'b0);
        push_exp(1'b1, 1'b0, 1'b0);
        compare_obs(tag);
    endtask

    function automatic logic [15:0] frame_8n1(input logic [7:0] d);
        logic [15:0] f;
        f    = '0;
        f[9] = 1'b0;
        for (int i = 0; i < 8; i++) f[8 - i] = d[i];
        f[0] = 1'b1;
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic ready_at_6;

        checks           = 0;
        failures         = 0;
        rec              = 1'b0;
        rst              = 1'b1;
        line_control_reg = 7'b0001000;
        data_input       = '0;
        data_valid       = 1'b0;
        set_break        = 1'b0;
        clear_obs();

        // Reset values
        #1;
        check("rst_tx",    64'(tx),         64'd1);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(frame_done), 64'd0);
        check("rst_ready", 64'(data_ready), 64'd1);
        check("rst_count", 64'(fifo_count), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single frames, hand-computed bit sequences
        run_frame("f8n1",   7'b0001000, 8'hA5, 16'b0101001011,  10);
        run_frame("f7e2",   7'b1010111, 8'hAE, 16'b00111010011, 11);
        run_frame("f5o1",   7'b0100101, 8'hFF, 16'b01111101,    8);
        run_frame("f5m1",   7'b1100101, 8'hFF, 16'b01111111,    8);
        run_frame("len_hi", 7'b0001111, 8'h3C, 16'b0001111001,  10);
        run_frame("len_lo", 7'b0000010, 8'h0A, 16'b0010101,     7);

        // FIFO full and back-to-back: words 01..06 on consecutive edges
        clear_obs();
        exp_q.delete();
        line_control_reg = 7'b0001000;
        rec              = 1'b1;
        ready_at_6       = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            data_input = 8'(k);
            data_valid = 1'b1;
            if (k == 6) ready_at_6 = data_ready;
            if (data_ready) exp_q.push_back(8'(k));
            tick();
        end
        data_valid = 1'b0;
        check("burst_ready6",   64'(ready_at_6),   64'd0);
        check("burst_accepted", 64'(exp_q.size()), 64'd5);
        check("burst_count6",   64'(fifo_count),   64'd4);
        for (int i = 0; i < 47; i++) tick();
        rec = 1'b0;
        check("burst_count_end", 64'(fifo_count), 64'd0);
        push_exp(1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            push_frame(frame_8n1(exp_q.pop_front()), 10);
        end
        push_exp(1'b1, 1'b0, 1'b0);
        push_exp(1'b1, 1'b0, 1'b0);
        compare_obs("burst");

        // Break raised mid-frame with a word still queued
        clear_obs();
        line_control_reg = 7'b0001000;
        data_input       = 8'h11;
        data_valid       = 1'b1;
        rec              = 1'b1;
        tick();
        data_input = 8'h22;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        set_break = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        check("brk_tx_low", 64'(tx),         64'd0);
        check("brk_count",  64'(fifo_count), 64'd1);
        set_break = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        rec = 1'b0;
        check("brk_count_end", 64'(fifo_count), 64'd0);
        push_exp(1'b1, 1'b0, 1'b0);
        push_frame(16'b0100010001, 10);
        for (int i = 0; i < 5; i++) push_exp(1'b0, 1'b1, 1'b0);
        push_exp(1'b1, 1'b0, 1'b0);
        push_frame(16'b0010001001, 10);
        push_exp(1'b1, 1'b0, 1'b0);
        push_exp(1'b1, 1'b0, 1'b0);
        compare_obs("brk");

        // Reset mid-frame with words queued
        line_control_reg = 7'b0001000;
        data_valid       = 1'b1;
        data_input       = 8'h5A;
        tick();
        data_input = 8'hC3;
        tick();
        data_input = 8'h96;
        tick();
        data_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_busy",  64'(busy),       64'd1);
        check("pre_rst_count", 64'(fifo_count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_tx",    64'(tx),         64'd1);
        check("mid_rst_busy",  64'(busy),       64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_ready", 64'(data_ready), 64'd1);
        tick();
        rst = 1'b0;
        clear_obs();
        rec = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        rec = 1'b0;
        for (int i = 0; i < 15; i++) push_exp(1'b1, 1'b0, 1'b0);
        compare_obs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised next-generation UART transmit path: accepts data words through a valid/ready handshake into an internal FIFO, builds frames with run-time data length, parity mode, stop-bit count and break, and serialises them on `tx`, one bit per `baud_clk` cycle. It replaces the fixed 11-bit control-unit-plus-PISO pair in the transmitter. It is driven by the baud generator's bit clock and fed by the host register interface.

## Interface
- `DATA_W`, 8: maximum data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, 4: transmit FIFO entries, power of 2, at least 2.
- `baud_clk`  in  1  bit clock; everything is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `line_control_reg`  in  7  line control fields:
  - [3:0] `data_len`; values below 5 are treated as 5, values above `DATA_W` as `DATA_W`.
  - [4] `stop2`: 0 selects 1 stop bit, 1 selects 2.
  - [6:5] parity mode: 00 none, 01 odd, 10 even, 11 mark (parity bit always 1).
- `data_input`  in  DATA_W  word to transmit.
- `data_valid`  in  1  write request.
- `data_ready`  out  1  high when the FIFO is not full.
- `set_break`  in  1  request to hold the line low.
- `tx`  out  1  serial line, registered, idles at 1.
- `busy`  out  1  high while a frame or break is on the line.
- `frame_done`  out  1  one-cycle pulse during the final stop bit.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- **Write:** a word is accepted on an edge where `data_valid && data_ready`. `data_ready = (fifo_count != FIFO_DEPTH)`. A write while full is dropped and has no side effects.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **Decision point:** IDLE, and the edge that ends the last stop bit.
  - If `set_break` is high, go to BREAK.
  - Else if the FIFO is non-empty, pop the head, latch the word and the decoded `line_control_reg` fields into frame registers, and go to START.
  - Otherwise go to IDLE.
- **Latching:** LCR and data changes during a frame have no effect on that frame.
- **START:** `tx=0` for 1 cycle.
- **DATA:** LSB first, `data_len` cycles. A bit counter is compared against the latched length. Bits at or above `data_len` are ignored.
- **PARITY:** entered only when the mode is not none; 1 cycle.
  - Odd: `~^data[len-1:0]`.
  - Even: `^data[len-1:0]`.
  - Mark: 1.
- **STOP:** `tx=1` for 1 or 2 cycles. `frame_done` is high during the last stop cycle.
- **Frame length:** 1 + L + P + S cycles (L=data bits, P=0/1 parity, S=1/2 stop), from 7 up to 13 for `DATA_W=9`.
- **BREAK:**
  - `tx=0` while `set_break` is high. The FIFO is not drained.
  - When `set_break` falls, go to IDLE with `tx=1`. At least one mark cycle precedes the next start bit.
- **`set_break` mid-frame:** the current frame completes, then BREAK is entered.
- **`busy`:** high in START, DATA, PARITY, STOP and BREAK; low in IDLE.
- **Simultaneous write and pop:** `fifo_count` is unchanged and both actions take effect. This is allowed even when the FIFO is full, provided `data_ready` was high when the write was presented.

## Timing
- **Reset values (asynchronous, immediate):**
  - `tx=1`, `busy=0`, `frame_done=0`, `data_ready=1`, `fifo_count=0`.
  - FIFO pointers cleared, state IDLE.
- **Reset mid-frame:** the frame is aborted and the line returns to mark at once. Queued words are discarded.
- **Start latency from an empty FIFO while in IDLE:** a word accepted on edge N shows its start bit on `tx` after edge N+1.
- **Back-to-back frames:** the start bit of the next frame follows the last stop bit on the next cycle, with no idle gap.
- **`data_ready`:** reflects the post-edge occupancy. It reasserts the cycle after a pop from a full FIFO.
- **`fifo_count`:** updates on the same edge as the write or pop.

## Test plan
- **Reset:** assert `rst` mid-frame → `tx=1`, `busy=0`, `fifo_count=0`, `data_ready=1` immediately. After release, `tx` stays 1 with no frame.
- **8N1:** `line_control_reg=7'b0001000`, `data_input=8'hA5` → `tx` = 0,1,0,1,0,0,1,0,1 then 1. That is 10 cycles, with `frame_done` high on the 10th.
- **7E2:** `line_control_reg=7'b1010111`, `data_input=8'hAE` → start 0; data 0,1,1,1,0,1,0; parity 0; stop 1,1. Total 11 cycles.
- **Odd and mark parity, short length:**
  - 5O1 (`7'b0100101`), `8'hFF` → data 1,1,1,1,1 then parity 0.
  - The same frame with mode 11 → parity 1.
- **FIFO full and back-to-back:** with `FIFO_DEPTH=4`, hold `data_valid` high with words 01..06 →
  - Exactly 5 words are accepted, then `data_ready=0` and word 06 is dropped.
  - Frames 01..05 go out in order with no gap between stop and start bits.
  - `fifo_count` reaches 0 after the 5th frame.
- **Break:** raise `set_break` mid-frame →
  - The frame completes and `frame_done` pulses.
  - `tx=0` while `set_break` is high, with queued words retained.
  - After release there is at least 1 mark cycle, then queued frames resume.
